// File: rtl/ascii_field_sender_pkg.sv
// Shared definitions for the ASCII field sender: FSM encoding, ASCII bytes,
// line-ending modes and the frame-length helper.
package ascii_field_sender_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CONVERT   = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int EOL_NONE = 0;
  localparam int EOL_CR   = 1;
  localparam int EOL_CRLF = 2;
  localparam int EOL_LF   = 3;

  // Digit code that can never be a real decimal digit; marks an out-of-range field.
  localparam logic [3:0] DIGIT_MARK = 4'hF;

  function automatic int eol_len(input int mode);
    case (mode)
      EOL_CR:   return 1;
      EOL_CRLF: return 2;
      EOL_LF:   return 1;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/ascii_field_sender_if.sv
// Byte handshake between the field sender (master) and a UART transmitter (slave).
interface ascii_field_sender_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  modport master (output tx_data, output tx_start, input tx_busy);
  modport slave  (input tx_data, input tx_start, output tx_busy);
endinterface

// File: rtl/ascii_field_sender_bin2dec99.sv
// Combinational binary to two-decimal-digit converter for values 0..99;
// larger values return the marker digit on both outputs and raise range_err_o.
module bin2dec99
  import ascii_field_sender_pkg::*;
#(
  parameter int FIELD_W = 7
) (
  input  logic [FIELD_W-1:0] bin_i,
  output logic [3:0]         tens_o,
  output logic [3:0]         ones_o,
  output logic               range_err_o
);

  logic [31:0] val;

  always_comb begin
    val         = 32'(bin_i);
    range_err_o = (val > 32'd99);
    tens_o      = DIGIT_MARK;
    ones_o      = DIGIT_MARK;
    if (!range_err_o) begin
      tens_o = 4'(val / 32'd10);
      ones_o = 4'(val % 32'd10);
    end
  end

endmodule

// File: rtl/ascii_field_sender.sv
// Snapshots NUM_FIELDS binary fields, converts them to two ASCII digits each and
// streams "dd<sep>dd...<eol>" one byte at a time through a start/busy UART handshake.
module ascii_field_sender
  import ascii_field_sender_pkg::*;
#(
  parameter int         NUM_FIELDS   = 3,
  parameter int         FIELD_W      = 7,
  parameter logic [7:0] SEP_CHAR     = ASCII_COLON,
  parameter int         EOL_MODE     = EOL_CRLF,
  parameter int         BUSY_TIMEOUT = 1023
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_send_trig,
  input  logic                          i_abort,
  input  logic [NUM_FIELDS*FIELD_W-1:0] i_fields,
  ascii_field_sender_if.master          tx,
  output logic                          o_is_sending,
  output logic                          o_done,
  output logic                          o_err,
  output logic                          o_range_err
);

  localparam int BODY_LEN  = 3*NUM_FIELDS - 1;
  localparam int FRAME_LEN = BODY_LEN + eol_len(EOL_MODE);
  localparam int CIDX_W    = $clog2(FRAME_LEN);

  state_t                        state_q;
  logic [NUM_FIELDS*FIELD_W-1:0] snap_q;
  logic [NUM_FIELDS*4-1:0]       tens_q;
  logic [NUM_FIELDS*4-1:0]       ones_q;
  logic [3:0]                    fidx_q;
  logic [CIDX_W-1:0]             cidx_q;
  logic [15:0]                   tmo_q;
  logic                          abort_pend_q;
  logic [7:0]                    tx_data_q;
  logic                          tx_start_q;
  logic                          done_q;
  logic                          err_q;
  logic                          range_err_q;

  logic [FIELD_W-1:0] conv_in;
  logic [3:0]         conv_tens;
  logic [3:0]         conv_ones;
  logic               conv_rng;
  logic [7:0]         tx_data_d;
  logic [3:0]         cur_digit;
  logic               last_byte;
  int                 ci_int;
  int                 fld_int;
  int                 pos_int;

  // One converter, walked across the snapshot one field per CONVERT cycle.
  assign conv_in = snap_q[int'(fidx_q)*FIELD_W +: FIELD_W];

  bin2dec99 #(.FIELD_W(FIELD_W)) u_bin2dec (
    .bin_i       (conv_in),
    .tens_o      (conv_tens),
    .ones_o      (conv_ones),
    .range_err_o (conv_rng)
  );

  // Byte at the current frame position: each field occupies 3 slots (tens, ones,
  // separator); the final separator slot is replaced by the line ending.
  always_comb begin
    ci_int    = int'(cidx_q);
    fld_int   = ci_int / 3;
    pos_int   = ci_int % 3;
    cur_digit = 4'h0;
    tx_data_d = ASCII_CR;
    if (ci_int < BODY_LEN) begin
      if (pos_int == 2) begin
        tx_data_d = SEP_CHAR;
      end else begin
        cur_digit = (pos_int == 0) ? tens_q[fld_int*4 +: 4] : ones_q[fld_int*4 +: 4];
        tx_data_d = (cur_digit == DIGIT_MARK) ? ASCII_DASH : (ASCII_ZERO + {4'h0, cur_digit});
      end
    end else if (EOL_MODE == EOL_LF || (EOL_MODE == EOL_CRLF && ci_int > BODY_LEN)) begin
      tx_data_d = ASCII_LF;
    end
  end

  assign last_byte = (cidx_q == CIDX_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      snap_q       <= '0;
      tens_q       <= '0;
      ones_q       <= '0;
      fidx_q       <= '0;
      cidx_q       <= '0;
      tmo_q        <= '0;
      abort_pend_q <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      range_err_q  <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      range_err_q <= 1'b0;
      if (i_send_trig && state_q != S_IDLE) err_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (i_send_trig && !i_abort) begin
            snap_q       <= i_fields;
            fidx_q       <= '0;
            abort_pend_q <= 1'b0;
            state_q      <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (i_abort) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tens_q[int'(fidx_q)*4 +: 4] <= conv_tens;
            ones_q[int'(fidx_q)*4 +: 4] <= conv_ones;
            range_err_q <= conv_rng;
            if (fidx_q == 4'(NUM_FIELDS - 1)) begin
              cidx_q  <= '0;
              state_q <= S_SEND;
            end else begin
              fidx_q <= fidx_q + 4'd1;
            end
          end
        end
        S_SEND: begin
          if (i_abort) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (!tx.tx_busy) begin
            tx_data_q  <= tx_data_d;
            tx_start_q <= 1'b1;
            tmo_q      <= '0;
            state_q    <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (i_abort) abort_pend_q <= 1'b1;
          if (tx.tx_busy) begin
            tx_start_q <= 1'b0;
            state_q    <= S_WAIT_DONE;
          end else if (tmo_q == 16'(BUSY_TIMEOUT - 1)) begin
            tx_start_q <= 1'b0;
            err_q      <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        S_WAIT_DONE: begin
          if (i_abort) abort_pend_q <= 1'b1;
          if (!tx.tx_busy) begin
            if (abort_pend_q || i_abort) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else if (last_byte) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              cidx_q  <= cidx_q + CIDX_W'(1);
              state_q <= S_SEND;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx.tx_data   = tx_data_q;
  assign tx.tx_start  = tx_start_q;
  assign o_is_sending = (state_q != S_IDLE);
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_range_err  = range_err_q;

endmodule
